rvh_l1d_mshr_file: RTL
======================

Name: rvh_l1d_mshr_file

Overview:
Holds the L1D miss status holding registers: per-entry valid/state/line address, allocation on a primary miss, L2 request issue, and release on refill.
Sits downstream of the L1D miss detect stage and upstream of the L2 request interface.
Drives the per-entry valid vector into the free-slot allocator (rvh_l1d_mshr_alloc) and consumes its free id, free flag and free count.
Also blocks duplicate misses to a line already in flight.

Parameters:
N_MSHR, 4, number of MSHR entries (>=2).
N_MSHR_W, $clog2(N_MSHR), entry id width.
PADDR_W, 56, physical address width.
LINE_OFS_W, 6, cache line offset bits (64B line).
REQ_TAG_W, 8, requester tag carried per entry.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
miss_req_valid_i  in  1  primary miss request
miss_req_paddr_i  in  PADDR_W  miss physical address
miss_req_tag_i  in  REQ_TAG_W  requester tag
miss_req_ready_o  out  1  request accepted this cycle
miss_req_id_o  out  N_MSHR_W  entry id allocated on acceptance
miss_hit_o  out  1  line already tracked by a valid entry
miss_hit_id_o  out  N_MSHR_W  matching entry id
l2_req_valid_o  out  1  L2 read request valid
l2_req_ready_i  in  1  L2 accepts request
l2_req_id_o  out  N_MSHR_W  entry id of request
l2_req_line_o  out  PADDR_W-LINE_OFS_W  line address
l2_resp_valid_i  in  1  refill complete for l2_resp_id_i
l2_resp_id_i  in  N_MSHR_W  refilled entry id
refill_tag_o  out  REQ_TAG_W  tag of entry named by l2_resp_id_i
mshr_valid_o  out  N_MSHR  per-entry valid vector
free_num_o  out  N_MSHR_W+1  free entry count
err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Per-entry state: INVALID -> PEND (allocated, not yet issued) -> WAIT (issued, awaiting refill) -> INVALID.
- Reset, asynchronous, also mid-operation:
  - all entries INVALID; err_o=0; l2_req_valid_o=0; mshr_valid_o=0; free_num_o=N_MSHR.
  - miss_hit_o=0 (nothing valid); miss_req_ready_o tracks miss_req_valid_i.
  - in-flight L2 transactions are abandoned; responses after reset follow the error rule.
- Line match: combinational compare of miss_req_paddr_i[PADDR_W-1:LINE_OFS_W] against every non-INVALID entry.
  - miss_hit_o is asserted only when miss_req_valid_i is high.
  - miss_hit_id_o is the lowest matching index; it is 0 when there is no hit.
- Acceptance: miss_req_ready_o = miss_req_valid_i & has_free & ~miss_hit_o.
  - miss_req_id_o = the allocator's lowest-index free entry.
  - On acceptance the entry becomes PEND at the next edge and captures the line address and tag.
  - On a hit the request is not accepted; the requester replays or merges.
- Issue:
  - l2_req_valid_o = any entry in PEND; the lowest-index PEND entry is selected.
  - id and line are held stable while valid is high and ready is low.
  - On valid & ready the entry moves to WAIT at the edge.
  - Minimum latency from acceptance edge to l2_req_valid_o is 1 cycle. A newly accepted entry is never issued in its acceptance cycle.
- Refill:
  - On l2_resp_valid_i, if entry l2_resp_id_i is in WAIT, it becomes INVALID at the edge.
  - refill_tag_o is combinational from the entry named by l2_resp_id_i.
  - A response to a PEND or INVALID entry: no state change, and err_o sets and stays set until reset.
- Simultaneous events:
  - A refill-free and an acceptance in the same cycle: acceptance uses the pre-edge valid vector, so the freed slot is usable the next cycle. The line match still includes the entry being freed (conservative hit).
  - Issue and refill of different entries in the same cycle are both applied.
- Full: all entries valid -> miss_req_ready_o=0, free_num_o=0.
- Empty: free_num_o=N_MSHR and l2_req_valid_o=0.
- mshr_valid_o = entry state != INVALID, registered; it feeds the allocator directly.

Decomposition:
- Shared package rvh_l1d_pkg holds:
  - the mshr_state_e enum: INVALID=2'd0, PEND=2'd1, WAIT=2'd2.
  - the mshr_entry_t struct {state, line, tag}.
  - the constants N_MSHR and LINE_OFS_W.
- Sub-module: rvh_l1d_mshr_alloc, instantiated once for free-id selection and free count.
- Lowest-index PEND selection and lowest-index hit selection are in-line priority logic.

Test Plan:
- Reset, then miss to 0x1000 -> ready=1, id=0; next cycle l2_req_valid_o=1, id=0, line=0x40; after ready, entry 0 is WAIT and free_num_o=3.
- 4 misses to distinct lines, then a 5th -> ready=0 and free_num_o=0; then resp id=2 -> next cycle a new miss is accepted with id=2.
- Second miss to 0x1020 while 0x1000 is in flight -> miss_hit_o=1, miss_hit_id_o=0, ready=0, no new entry.
- l2_req_ready_i held low for 5 cycles while 2 entries are PEND -> id=0 stays stable throughout; id=1 is issued the cycle after the handshake.
- Response to an INVALID entry id=3 -> err_o=1 sticky, no state change; rst pulse mid-traffic -> all outputs return to reset values immediately.
- Refill id=1 and new miss in the same cycle with entry 1 the only free-after-edge slot and entries 0,2,3 valid -> this cycle ready=0; next cycle ready=1, id=1.

Source files
------------

// File: rtl/rvh_l1d_pkg.sv
// Shared L1D miss-handling types: MSHR entry state encoding and entry record.
package rvh_l1d_pkg;

  localparam int N_MSHR     = 4;
  localparam int LINE_OFS_W = 6;
  localparam int PADDR_W    = 56;
  localparam int REQ_TAG_W  = 8;
  localparam int LINE_W     = PADDR_W - LINE_OFS_W;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    PEND    = 2'd1,
    WAIT    = 2'd2
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e            state;
    logic [LINE_W-1:0]      line;
    logic [REQ_TAG_W-1:0]   tag;
  } mshr_entry_t;

endpackage

// File: rtl/rvh_l1d_mshr_alloc.sv
// Free-slot allocator: lowest-index free MSHR entry and number of free entries.
module rvh_l1d_mshr_alloc #(
  parameter int N_MSHR   = 4,
  parameter int N_MSHR_W = $clog2(N_MSHR)
) (
  input  logic [N_MSHR-1:0]   valid_i,
  output logic [N_MSHR_W-1:0] free_id_o,
  output logic                has_free_o,
  output logic [N_MSHR_W:0]   free_num_o
);

  always_comb begin
    free_id_o  = '0;
    has_free_o = 1'b0;
    free_num_o = '0;
    // Walk downwards so the last hit written is the lowest free index.
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_id_o  = N_MSHR_W'(i);
        has_free_o = 1'b1;
        free_num_o = free_num_o + (N_MSHR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/rvh_l1d_mshr_file.sv
// L1D MSHR file: allocates entries on primary misses, issues L2 reads in
// index order, releases entries on refill and blocks duplicate line misses.
module rvh_l1d_mshr_file #(
  parameter int N_MSHR     = 4,
  parameter int N_MSHR_W   = $clog2(N_MSHR),
  parameter int PADDR_W    = 56,
  parameter int LINE_OFS_W = 6,
  parameter int REQ_TAG_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_req_valid_i,
  input  logic [PADDR_W-1:0]            miss_req_paddr_i,
  input  logic [REQ_TAG_W-1:0]          miss_req_tag_i,
  output logic                          miss_req_ready_o,
  output logic [N_MSHR_W-1:0]           miss_req_id_o,
  output logic                          miss_hit_o,
  output logic [N_MSHR_W-1:0]           miss_hit_id_o,
  output logic                          l2_req_valid_o,
  input  logic                          l2_req_ready_i,
  output logic [N_MSHR_W-1:0]           l2_req_id_o,
  output logic [PADDR_W-LINE_OFS_W-1:0] l2_req_line_o,
  input  logic                          l2_resp_valid_i,
  input  logic [N_MSHR_W-1:0]           l2_resp_id_i,
  output logic [REQ_TAG_W-1:0]          refill_tag_o,
  output logic [N_MSHR-1:0]             mshr_valid_o,
  output logic [N_MSHR_W:0]             free_num_o,
  output logic                          err_o
);
  import rvh_l1d_pkg::*;

  mshr_entry_t                    entry_q [N_MSHR];
  mshr_entry_t                    entry_d [N_MSHR];
  logic                           err_q, err_d;
  logic                           hold_q, hold_d;
  logic [N_MSHR_W-1:0]            hold_id_q, hold_id_d;
  logic [PADDR_W-LINE_OFS_W-1:0]  req_line;
  logic [N_MSHR-1:0]              valid_vec;
  logic [N_MSHR_W-1:0]            free_id;
  logic                           has_free;
  logic                           hit_found;
  logic [N_MSHR_W-1:0]            hit_idx;
  logic                           pend_found;
  logic [N_MSHR_W-1:0]            pend_idx;
  logic [N_MSHR_W-1:0]            issue_id;

  rvh_l1d_mshr_alloc #(
    .N_MSHR   (N_MSHR),
    .N_MSHR_W (N_MSHR_W)
  ) u_alloc (
    .valid_i    (valid_vec),
    .free_id_o  (free_id),
    .has_free_o (has_free),
    .free_num_o (free_num_o)
  );

  always_comb begin
    req_line   = miss_req_paddr_i[PADDR_W-1:LINE_OFS_W];
    valid_vec  = '0;
    hit_found  = 1'b0;
    hit_idx    = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      valid_vec[i] = (entry_q[i].state != INVALID);
      if (valid_vec[i] && (entry_q[i].line == req_line)) begin
        hit_found = 1'b1;
        hit_idx   = N_MSHR_W'(i);
      end
      if (entry_q[i].state == PEND) begin
        pend_found = 1'b1;
        pend_idx   = N_MSHR_W'(i);
      end
    end
  end

  assign mshr_valid_o     = valid_vec;
  assign miss_hit_o       = miss_req_valid_i & hit_found;
  assign miss_hit_id_o    = miss_hit_o ? hit_idx : '0;
  assign miss_req_ready_o = miss_req_valid_i & has_free & ~hit_found;
  assign miss_req_id_o    = free_id;
  // A stalled request keeps its entry even if a lower slot becomes PEND meanwhile.
  assign issue_id         = hold_q ? hold_id_q : pend_idx;
  assign l2_req_valid_o   = pend_found;
  assign l2_req_id_o      = issue_id;
  assign l2_req_line_o    = entry_q[issue_id].line;
  assign refill_tag_o     = entry_q[l2_resp_id_i].tag;
  assign err_o            = err_q;

  always_comb begin
    entry_d   = entry_q;
    err_d     = err_q;
    hold_d    = pend_found & ~l2_req_ready_i;
    hold_id_d = issue_id;
    if (pend_found && l2_req_ready_i) begin
      entry_d[issue_id].state = WAIT;
    end
    if (l2_resp_valid_i) begin
      if (entry_q[l2_resp_id_i].state == WAIT) begin
        entry_d[l2_resp_id_i].state = INVALID;
      end else begin
        err_d = 1'b1;
      end
    end
    // Allocation targets a slot that is free before the edge, never one being refilled.
    if (miss_req_ready_o) begin
      entry_d[free_id].state = PEND;
      entry_d[free_id].line  = req_line;
      entry_d[free_id].tag   = miss_req_tag_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MSHR; i++) begin
        entry_q[i] <= '0;
      end
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
      hold_id_q <= '0;
    end else begin
      entry_q   <= entry_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
    end
  end

endmodule
